keypad_entry: RTL and testbench

Front end of the microwave keypad path. It synchronises and debounces the raw 10-key keypad, encodes a single key press to BCD, and shifts accepted digits into a 3-digit cook-time entry buffer (M:ST:SO). micro_waves_control reads this buffer for the minutes, tens-of-seconds and ones-of-seconds values it counts down and shows on its 7-segment outputs.

---
 rtl/micro_waves_pkg.sv | 35 +++
 rtl/keypad_sync.sv | 27 ++
 rtl/keypad_entry.sv | 138 +++++++++++++
 tb/tb_keypad_entry.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_waves_pkg.sv
// Shared types and helpers for the microwave keypad path: FSM state
// encoding, digit/key widths and the one-hot key decode helpers.
package micro_waves_pkg;

    localparam int BCD_W = 4;
    localparam int KEYS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } kp_state_t;

    // Index of the set bit of a one-hot key vector, as a BCD digit.
    function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEYS-1:0] oh);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (oh[i]) bcd = BCD_W'(i);
        end
        return bcd;
    endfunction

    // True when exactly one key line is set.
    function automatic logic is_one_hot(input logic [KEYS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEYS; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the raw, asynchronous keypad lines.
module keypad_sync
    import micro_waves_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic [KEYS-1:0] i_async,
    output logic [KEYS-1:0] o_sync
);

    logic [KEYS-1:0] r_meta;
    logic [KEYS-1:0] r_sync;

    // Shift raw key levels through two flops to settle metastability.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: synchronise, debounce, BCD-encode one key press and
// shift accepted digits into the 3-digit M:ST:SO cook-time entry buffer.
//
// Output handshake: digit/digit_valid is a valid-only stream with no ready.
// digit_valid is high for exactly one cycle per accepted press; digit is
// meaningful on that cycle and then holds the last accepted key until the
// next acceptance. The consumer must take the digit on the pulse cycle.
module keypad_entry
    import micro_waves_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [KEYS-1:0]  keypad,
    input  logic             clearn,
    input  logic             load_en,
    output logic [BCD_W-1:0] digit,
    output logic             digit_valid,
    output logic             key_error,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] sec_tens_bcd,
    output logic [BCD_W-1:0] sec_ones_bcd,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEYS-1:0]  w_ks;
    logic             w_accept;
    logic [BCD_W-1:0] w_accept_digit;

    kp_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KEYS-1:0]  r_key;
    logic [BCD_W-1:0] r_digit;
    logic             r_valid;
    logic             r_key_error;
    logic [BCD_W-1:0] r_min;
    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;

    keypad_sync u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (keypad),
        .o_sync  (w_ks)
    );

    // The latched key has held steady for the full debounce window this cycle.
    assign w_accept       = (r_state == ST_DEB_PRESS) && (w_ks == r_key) && (r_cnt == CNT_LAST);
    assign w_accept_digit = onehot_to_bcd(r_key);

    // Debounce FSM: press qualification, hold without repeat, release qualification.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_key       <= '0;
            r_digit     <= '0;
            r_valid     <= 1'b0;
            r_key_error <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (is_one_hot(w_ks)) begin
                        r_key       <= w_ks;
                        r_cnt       <= CNT_ONE;
                        r_key_error <= 1'b0;
                        r_state     <= ST_DEB_PRESS;
                    end else begin
                        // Zero keys clears the flag, two or more sets it.
                        r_key_error <= (w_ks != '0);
                    end
                end
                ST_DEB_PRESS: begin
                    if (w_ks != r_key) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_digit <= w_accept_digit;
                        r_valid <= 1'b1;
                        r_state <= ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    // Any held key pattern is ignored until all keys are up.
                    if (w_ks == '0) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= ST_DEB_RELEASE;
                    end
                end
                ST_DEB_RELEASE: begin
                    if (w_ks != '0) begin
                        r_state <= ST_HELD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Entry buffer: clear wins over a same-cycle shift of the accepted digit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_min  <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else if (!clearn) begin
            r_min  <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else if (w_accept && load_en) begin
            r_min  <= r_tens;
            r_tens <= r_ones;
            r_ones <= w_accept_digit;
        end
    end

    assign digit        = r_digit;
    assign digit_valid  = r_valid;
    assign key_error    = r_key_error;
    assign min_bcd      = r_min;
    assign sec_tens_bcd = r_tens;
    assign sec_ones_bcd = r_ones;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural acceptance model,
// a per-cycle compare process and literal checkpoints per scenario.
module tb_keypad_entry;

  localparam int D = 4;

  logic       clk;
  logic       resetn;
  logic [9:0] keypad;
  logic       clearn;
  logic       load_en;
  logic [3:0] digit;
  logic       digit_valid;
  logic       key_error;
  logic [3:0] min_bcd;
  logic [3:0] sec_tens_bcd;
  logic [3:0] sec_ones_bcd;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .keypad       (keypad),
    .clearn       (clearn),
    .load_en      (load_en),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .key_error    (key_error),
    .min_bcd      (min_bcd),
    .sec_tens_bcd (sec_tens_bcd),
    .sec_ones_bcd (sec_ones_bcd),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Acceptance rule: after the keys have been fully up for D sampled cycles
  // (or after reset), a single key seen alone for D consecutive sampled
  // cycles is accepted once. The buffer is the last three accepted digits
  // as a decimal number mod 1000.
  logic [3:0] exp_q[$];
  logic [9:0] m_s1, m_ks, m_cand;
  int         m_phase;   // 0 waiting for a key, 1 qualifying a key, 2 key accepted
  int         m_run;
  logic [3:0] m_digit;
  logic       m_valid;
  logic       m_err;
  int         m_entry;

  function automatic logic [3:0] key_index(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = '0; m_ks = '0; m_cand = '0;
      m_phase = 0; m_run = 0;
      m_digit = '0; m_valid = 1'b0; m_err = 1'b0; m_entry = 0;
      exp_q.delete();
    end else begin
      logic acc;
      acc = 1'b0;
      m_valid = 1'b0;
      if (m_phase == 0) begin
        if ($countones(m_ks) == 1) begin
          m_cand = m_ks; m_run = 1; m_phase = 1; m_err = 1'b0;
        end else begin
          m_err = ($countones(m_ks) >= 2);
        end
      end else if (m_phase == 1) begin
        if (m_ks != m_cand) m_phase = 0;
        else begin
          m_run++;
          if (m_run == D) begin acc = 1'b1; m_phase = 2; m_run = 0; end
        end
      end else begin
        if (m_ks == '0) begin
          m_run++;
          if (m_run == D) begin m_phase = 0; m_run = 0; end
        end else m_run = 0;
      end
      if (acc) begin
        m_digit = key_index(m_cand);
        m_valid = 1'b1;
        exp_q.push_back(m_digit);
      end
      if (!clearn) m_entry = 0;
      else if (acc && load_en) m_entry = (m_entry * 10 + int'(m_digit)) % 1000;
      m_ks = m_s1;
      m_s1 = keypad;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check_eq("digit_valid", int'(digit_valid), int'(m_valid));
    check_eq("key_error", int'(key_error), int'(m_err));
    check_eq("digit", int'(digit), int'(m_digit));
    check_eq("min_bcd", int'(min_bcd), m_entry / 100);
    check_eq("sec_tens_bcd", int'(sec_tens_bcd), (m_entry / 10) % 10);
    check_eq("sec_ones_bcd", int'(sec_ones_bcd), m_entry % 10);
    if (digit_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_pulse", 1, 0);
      else check_eq("scoreboard_digit", int'(digit), int'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_release(input int k);
    @(negedge clk) keypad = 10'(1 << k);
    repeat (8) @(negedge clk);
    keypad = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_buf(input string name, input int m, input int t, input int o);
    check_eq({name, "_min"}, int'(min_bcd), m);
    check_eq({name, "_tens"}, int'(sec_tens_bcd), t);
    check_eq({name, "_ones"}, int'(sec_ones_bcd), o);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int p0;
    logic [9:0] bounce [5];
    bounce[0] = 10'h080; bounce[1] = 10'h000; bounce[2] = 10'h080;
    bounce[3] = 10'h080; bounce[4] = 10'h000;

    resetn = 1'b0; keypad = '0; clearn = 1'b1; load_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", int'(digit_valid), 0);
    check_eq("rst_digit", int'(digit), 0);
    check_eq("rst_err", int'(key_error), 0);
    check_buf("rst", 0, 0, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean key 5, exact latency and width
    keypad = 10'(1 << 5);
    repeat (5) @(posedge clk);
    #1 check_eq("t1_early", int'(digit_valid), 0);
    @(posedge clk);
    #1 check_eq("t1_valid", int'(digit_valid), 1);
    check_eq("t1_digit", int'(digit), 5);
    check_eq("t1_ones", int'(sec_ones_bcd), 5);
    @(posedge clk);
    #1 check_eq("t1_width", int'(digit_valid), 0);
    @(negedge clk) keypad = '0;
    repeat (10) @(negedge clk);

    // 2: 1,3,0,4 -> 3:0:4
    p0 = pulse_cnt;
    press_release(1); press_release(3); press_release(0); press_release(4);
    check_eq("t2_pulses", pulse_cnt - p0, 4);
    check_buf("t2", 3, 0, 4);

    // 3: bouncing 7 then long hold
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      keypad = bounce[i];
      @(negedge clk);
    end
    keypad = 10'(1 << 7);
    repeat (60) @(negedge clk);
    check_eq("t3_pulses", pulse_cnt - p0, 1);
    check_eq("t3_digit", int'(digit), 7);
    keypad = '0;
    repeat (10) @(negedge clk);

    // 4: 2 and 8 together, then release 8
    p0 = pulse_cnt;
    keypad = 10'(1 << 2) | 10'(1 << 8);
    repeat (10) @(negedge clk);
    check_eq("t4_err_on", int'(key_error), 1);
    check_eq("t4_no_pulse", pulse_cnt - p0, 0);
    keypad = 10'(1 << 2);
    repeat (3) @(posedge clk);
    #1 check_eq("t4_err_off", int'(key_error), 0);
    repeat (8) @(negedge clk);
    check_eq("t4_pulses", pulse_cnt - p0, 1);
    check_eq("t4_digit", int'(digit), 2);
    keypad = '0;
    repeat (10) @(negedge clk);

    // 5: load_en=0 hold, then clear colliding with a load
    clearn = 1'b0;
    @(negedge clk) clearn = 1'b1;
    press_release(1); press_release(2); press_release(3);
    check_buf("t5_load", 1, 2, 3);
    load_en = 1'b0;
    p0 = pulse_cnt;
    press_release(9);
    check_eq("t5_pulse9", pulse_cnt - p0, 1);
    check_eq("t5_digit9", int'(digit), 9);
    check_buf("t5_hold", 1, 2, 3);
    load_en = 1'b1;
    @(negedge clk) keypad = 10'(1 << 6);
    repeat (5) @(posedge clk);
    @(negedge clk) clearn = 1'b0;
    @(posedge clk);
    #1 check_eq("t5_valid6", int'(digit_valid), 1);
    check_eq("t5_digit6", int'(digit), 6);
    check_buf("t5_clear", 0, 0, 0);
    @(negedge clk) clearn = 1'b1;
    keypad = '0;
    repeat (10) @(negedge clk);

    // 6: asynchronous reset mid-press, key still held afterwards
    keypad = 10'(1 << 4);
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_eq("t6_rst_digit", int'(digit), 0);
    check_eq("t6_rst_state", int'(dbg_state), 0);
    check_buf("t6_rst", 0, 0, 0);
    @(negedge clk) resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_eq("t6_early", int'(digit_valid), 0);
    @(posedge clk);
    #1 check_eq("t6_valid", int'(digit_valid), 1);
    check_eq("t6_digit", int'(digit), 4);
    check_eq("t6_ones", int'(sec_ones_bcd), 4);
    @(negedge clk) keypad = '0;
    repeat (10) @(negedge clk);
    check_eq("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
